// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC redirect owner: arbitrates BTB predictions against ID mispredict
// corrections, holds redirects until IF consumes them, and sequences the flush.
module pc_redirect_ctrl #(
  parameter int FLUSH_DEPTH = 7,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             pred_req_IN,
  input  logic [31:0]      pred_pc_IN,
  input  logic             resolve_valid_IN,
  input  logic             resolve_mispredict_IN,
  input  logic [31:0]      resolve_pc_IN,
  output logic             Request_Alt_PC_OUT,
  output logic [31:0]      Alt_PC_OUT,
  output logic             FLUSH_OUT,
  output logic             flush_busy_OUT,
  output logic [CNT_W-1:0] branch_count_OUT,
  output logic [CNT_W-1:0] mispredict_count_OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_DEPTH - 1);

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      alt_pc_q, alt_pc_d;
  logic             flush_q, flush_d;
  logic             busy_q, busy_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;

  logic consume;
  logic accept;
  logic mispredict;

  assign consume    = req_q && !STALL;
  assign accept     = resolve_valid_IN && !STALL && (state_q != FLUSH);
  assign mispredict = accept && resolve_mispredict_IN;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    alt_pc_d     = alt_pc_q;
    flush_d      = flush_q;
    busy_d       = busy_q;
    fcnt_d       = fcnt_q;
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;

    if (accept && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (mispredict && (misp_cnt_q != '1))
      misp_cnt_d = misp_cnt_q + CNT_W'(1);

    if (consume)
      req_d = 1'b0;

    case (state_q)
      IDLE, HOLD: begin
        // Mispredict beats both a pending hold and a same-cycle prediction.
        if (mispredict) begin
          state_d  = FLUSH;
          req_d    = 1'b1;
          alt_pc_d = resolve_pc_IN;
          flush_d  = 1'b1;
          busy_d   = 1'b1;
          fcnt_d   = FLUSH_INIT;
        end else if (pred_req_IN && ((state_q == IDLE) || consume)) begin
          state_d  = HOLD;
          req_d    = 1'b1;
          alt_pc_d = pred_pc_IN;
        end else if ((state_q == HOLD) && consume) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        // The flush window is fixed length; only leaving the state waits on IF.
        if (fcnt_q != 4'd0) begin
          fcnt_d = fcnt_q - 4'd1;
        end else begin
          flush_d = 1'b0;
          if (!req_q || consume) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        flush_d = 1'b0;
        busy_d  = 1'b0;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      alt_pc_q     <= 32'h0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      fcnt_q       <= 4'd0;
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      alt_pc_q     <= alt_pc_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
      fcnt_q       <= fcnt_d;
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign Request_Alt_PC_OUT   = req_q;
  assign Alt_PC_OUT           = alt_pc_q;
  assign FLUSH_OUT            = flush_q;
  assign flush_busy_OUT       = busy_q;
  assign branch_count_OUT     = branch_cnt_q;
  assign mispredict_count_OUT = misp_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a default instance plus a CNT_W=4 copy
// sharing the same stimulus for the counter saturation scenario.
module tb_pc_redirect_ctrl;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        pred_req_IN;
  logic [31:0] pred_pc_IN;
  logic        resolve_valid_IN;
  logic        resolve_mispredict_IN;
  logic [31:0] resolve_pc_IN;

  logic        req;
  logic [31:0] alt_pc;
  logic        flush;
  logic        busy;
  logic [31:0] branch_cnt;
  logic [31:0] misp_cnt;

  logic        s_req;
  logic [31:0] s_alt_pc;
  logic        s_flush;
  logic        s_busy;
  logic [3:0]  s_branch_cnt;
  logic [3:0]  s_misp_cnt;

  int total;
  int bad;

  pc_redirect_ctrl #(.FLUSH_DEPTH(7), .CNT_W(32)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .STALL                (STALL),
    .pred_req_IN          (pred_req_IN),
    .pred_pc_IN           (pred_pc_IN),
    .resolve_valid_IN     (resolve_valid_IN),
    .resolve_mispredict_IN(resolve_mispredict_IN),
    .resolve_pc_IN        (resolve_pc_IN),
    .Request_Alt_PC_OUT   (req),
    .Alt_PC_OUT           (alt_pc),
    .FLUSH_OUT            (flush),
    .flush_busy_OUT       (busy),
    .branch_count_OUT     (branch_cnt),
    .mispredict_count_OUT (misp_cnt)
  );

  pc_redirect_ctrl #(.FLUSH_DEPTH(7), .CNT_W(4)) dut_small (
    .CLK                  (CLK),
    .RESET                (RESET),
    .STALL                (STALL),
    .pred_req_IN          (pred_req_IN),
    .pred_pc_IN           (pred_pc_IN),
    .resolve_valid_IN     (resolve_valid_IN),
    .resolve_mispredict_IN(resolve_mispredict_IN),
    .resolve_pc_IN        (resolve_pc_IN),
    .Request_Alt_PC_OUT   (s_req),
    .Alt_PC_OUT           (s_alt_pc),
    .FLUSH_OUT            (s_flush),
    .flush_busy_OUT       (s_busy),
    .branch_count_OUT     (s_branch_cnt),
    .mispredict_count_OUT (s_misp_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Outputs are sampled 1 time unit after the edge they change on.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    STALL                 = 1'b0;
    pred_req_IN           = 1'b0;
    pred_pc_IN            = 32'h0;
    resolve_valid_IN      = 1'b0;
    resolve_mispredict_IN = 1'b0;
    resolve_pc_IN         = 32'h0;
  endtask

  task automatic test_reset();
    RESET                 = 1'b1;
    STALL                 = 1'b0;
    pred_req_IN           = 1'b1;
    pred_pc_IN            = 32'hDEAD_BEEF;
    resolve_valid_IN      = 1'b1;
    resolve_mispredict_IN = 1'b1;
    resolve_pc_IN         = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({req, flush, busy} !== 3'b000 || alt_pc !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_outputs: req/flush/busy=%b alt=%h expected 000 alt=00000000",
                 {req, flush, busy}, alt_pc);
      end
      total++;
      if (branch_cnt !== 32'd0 || misp_cnt !== 32'd0) begin
        bad++;
        $display("[TB] FAIL reset_counters: branch=%0d misp=%0d expected 0 0", branch_cnt, misp_cnt);
      end
    end
    RESET = 1'b0;
    clear_inputs();
    tick();
    total++;
    if (branch_cnt !== 32'd0 || misp_cnt !== 32'd0 || req !== 1'b0 || flush !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset: branch=%0d misp=%0d req=%b flush=%b expected 0 0 0 0",
               branch_cnt, misp_cnt, req, flush);
    end
  endtask

  task automatic test_predict();
    pred_req_IN = 1'b1;
    pred_pc_IN  = 32'h0040_0100;
    tick();
    pred_req_IN = 1'b0;
    total++;
    if (req !== 1'b1 || alt_pc !== 32'h0040_0100 || flush !== 1'b0) begin
      bad++;
      $display("[TB] FAIL predict_redirect: req=%b alt=%h flush=%b expected 1 00400100 0",
               req, alt_pc, flush);
    end
    tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL predict_consumed: req=%b expected 0", req);
    end
  endtask

  task automatic test_predict_stall();
    int high_cycles;
    int alt_bad;
    high_cycles = 0;
    alt_bad     = 0;
    STALL       = 1'b1;
    pred_req_IN = 1'b1;
    pred_pc_IN  = 32'h0040_0110;
    tick();
    for (int i = 1; i <= 8; i++) begin
      pred_req_IN = (i == 1);
      pred_pc_IN  = 32'h0040_0990;
      STALL       = (i <= 3);
      if (req === 1'b1) begin
        high_cycles++;
        if (alt_pc !== 32'h0040_0110) alt_bad++;
      end
      tick();
    end
    clear_inputs();
    total++;
    if (high_cycles != 4) begin
      bad++;
      $display("[TB] FAIL stall_hold_len: got %0d cycles expected 4", high_cycles);
    end
    total++;
    if (alt_bad != 0) begin
      bad++;
      $display("[TB] FAIL stall_alt_stable: got %0d unstable cycles expected 0", alt_bad);
    end
    total++;
    if (req !== 1'b0 || flush !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_second_pred_ignored: req=%b flush=%b expected 0 0", req, flush);
    end
  endtask

  task automatic test_back_to_back();
    pred_req_IN = 1'b1;
    pred_pc_IN  = 32'h0040_0120;
    tick();
    pred_pc_IN  = 32'h0040_0140;
    total++;
    if (req !== 1'b1 || alt_pc !== 32'h0040_0120) begin
      bad++;
      $display("[TB] FAIL b2b_first: req=%b alt=%h expected 1 00400120", req, alt_pc);
    end
    tick();
    pred_req_IN = 1'b0;
    total++;
    if (req !== 1'b1 || alt_pc !== 32'h0040_0140) begin
      bad++;
      $display("[TB] FAIL b2b_reload: req=%b alt=%h expected 1 00400140", req, alt_pc);
    end
    tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_drain: req=%b expected 0", req);
    end
  endtask

  task automatic test_mispredict();
    int flush_cycles;
    int req_cycles;
    resolve_valid_IN      = 1'b1;
    resolve_mispredict_IN = 1'b1;
    resolve_pc_IN         = 32'h0040_0200;
    tick();
    clear_inputs();
    total++;
    if (req !== 1'b1 || alt_pc !== 32'h0040_0200 || flush !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL misp_entry: req=%b alt=%h flush=%b busy=%b expected 1 00400200 1 1",
               req, alt_pc, flush, busy);
    end
    flush_cycles = 0;
    req_cycles   = 0;
    for (int i = 0; i < 20 && flush === 1'b1; i++) begin
      flush_cycles++;
      if (req === 1'b1) req_cycles++;
      resolve_valid_IN      = (i == 1) || (i == 3);
      resolve_mispredict_IN = (i == 3);
      tick();
      clear_inputs();
    end
    total++;
    if (flush_cycles != 7) begin
      bad++;
      $display("[TB] FAIL misp_flush_len: got %0d cycles expected 7", flush_cycles);
    end
    total++;
    if (req_cycles != 1) begin
      bad++;
      $display("[TB] FAIL misp_redirect_len: got %0d cycles expected 1", req_cycles);
    end
    total++;
    if (busy !== 1'b0 || req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL misp_exit: busy=%b req=%b expected 0 0", busy, req);
    end
    total++;
    if (branch_cnt !== 32'd1 || misp_cnt !== 32'd1) begin
      bad++;
      $display("[TB] FAIL misp_counters: branch=%0d misp=%0d expected 1 1", branch_cnt, misp_cnt);
    end
  endtask

  task automatic test_simultaneous();
    int pred_seen;
    STALL       = 1'b1;
    pred_req_IN = 1'b1;
    pred_pc_IN  = 32'h0040_0100;
    tick();
    total++;
    if (req !== 1'b1 || alt_pc !== 32'h0040_0100) begin
      bad++;
      $display("[TB] FAIL sim_hold: req=%b alt=%h expected 1 00400100", req, alt_pc);
    end
    STALL                 = 1'b0;
    pred_req_IN           = 1'b1;
    pred_pc_IN            = 32'h0040_0300;
    resolve_valid_IN      = 1'b1;
    resolve_mispredict_IN = 1'b1;
    resolve_pc_IN         = 32'h0040_0204;
    tick();
    clear_inputs();
    total++;
    if (alt_pc !== 32'h0040_0204 || flush !== 1'b1 || req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sim_priority: alt=%h flush=%b req=%b expected 00400204 1 1",
               alt_pc, flush, req);
    end
    pred_seen = 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin
      if (req === 1'b1 && alt_pc !== 32'h0040_0204) pred_seen++;
      tick();
    end
    total++;
    if (pred_seen != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sim_no_prediction: stray=%0d busy=%b expected 0 0", pred_seen, busy);
    end
    total++;
    if (branch_cnt !== 32'd2 || misp_cnt !== 32'd2) begin
      bad++;
      $display("[TB] FAIL sim_counters: branch=%0d misp=%0d expected 2 2", branch_cnt, misp_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    resolve_valid_IN      = 1'b1;
    resolve_mispredict_IN = 1'b1;
    resolve_pc_IN         = 32'h0040_0208;
    tick();
    clear_inputs();
    tick();
    total++;
    if (flush !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midflush_active: flush=%b busy=%b expected 1 1", flush, busy);
    end
    RESET = 1'b1;
    tick();
    total++;
    if (flush !== 1'b0 || req !== 1'b0 || busy !== 1'b0 || alt_pc !== 32'h0) begin
      bad++;
      $display("[TB] FAIL midflush_reset: flush=%b req=%b busy=%b alt=%h expected 0 0 0 00000000",
               flush, req, busy, alt_pc);
    end
    RESET = 1'b0;
    tick();
    total++;
    if (flush !== 1'b0 || req !== 1'b0 || branch_cnt !== 32'd0 || misp_cnt !== 32'd0) begin
      bad++;
      $display("[TB] FAIL midflush_after: flush=%b req=%b branch=%0d misp=%0d expected 0 0 0 0",
               flush, req, branch_cnt, misp_cnt);
    end
  endtask

  task automatic test_saturation();
    resolve_valid_IN      = 1'b1;
    resolve_mispredict_IN = 1'b0;
    resolve_pc_IN         = 32'h0040_0400;
    for (int i = 0; i < 17; i++) tick();
    clear_inputs();
    tick();
    total++;
    if (s_branch_cnt !== 4'hF || s_misp_cnt !== 4'h0) begin
      bad++;
      $display("[TB] FAIL sat_small: branch=%h misp=%h expected f 0", s_branch_cnt, s_misp_cnt);
    end
    total++;
    if (branch_cnt !== 32'd17 || misp_cnt !== 32'd0 || req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sat_wide: branch=%0d misp=%0d req=%b expected 17 0 0",
               branch_cnt, misp_cnt, req);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b1;
    clear_inputs();
    test_reset();
    test_predict();
    test_predict_stall();
    test_back_to_back();
    test_mispredict();
    test_simultaneous();
    test_reset_mid_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
